// File: rtl/softmax_sum_normalizer_pkg.sv
// Shared constants and types for the softmax sum normalizer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: width derivations, FSM state enum, saturation constant, result struct, saturating add.
package softmax_sum_normalizer_pkg;

  localparam int IN_WIDTH   = 8;
  localparam int N_MAX      = 16;
  localparam int ACC_WIDTH  = IN_WIDTH + $clog2(N_MAX);
  localparam int MANT_WIDTH = 8;
  localparam int EXP_WIDTH  = $clog2(ACC_WIDTH);
  // Counter must be able to hold N_MAX itself so "already N_MAX beats" is visible.
  localparam int CNT_WIDTH  = $clog2(N_MAX + 1);

  localparam logic [ACC_WIDTH-1:0] ACC_SAT = {ACC_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    ACCUM,
    NORM,
    HOLD
  } state_t;

  typedef struct packed {
    logic [MANT_WIDTH-1:0] mant;
    logic [EXP_WIDTH-1:0]  expn;
    logic                  zero;
  } norm_t;

  // Returns {saturated, result}; result clamps at ACC_SAT on carry-out.
  function automatic logic [ACC_WIDTH:0] sat_add(input logic [ACC_WIDTH-1:0] a,
                                                 input logic [IN_WIDTH-1:0]  b);
    logic [ACC_WIDTH:0] s;
    s = {1'b0, a} + (ACC_WIDTH + 1)'(b);
    if (s[ACC_WIDTH]) begin
      return {1'b1, ACC_SAT};
    end
    return s;
  endfunction

endpackage

// File: rtl/softmax_sum_normalizer_if.sv
// Term stream in, normalized result out, both valid/ready.
// Latency: n/a (signal bundle).
// Backpressure: in_ready gates terms, out_ready holds the result.
// master = producer/consumer side (testbench), slave = normalizer.
interface softmax_sum_normalizer_if;
  import softmax_sum_normalizer_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic [IN_WIDTH-1:0]   in_data;
  logic                  in_last;
  logic                  out_valid;
  logic                  out_ready;
  logic [MANT_WIDTH-1:0] out_mant;
  logic [EXP_WIDTH-1:0]  out_exp;
  logic                  out_zero;
  logic                  out_ovf;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_mant, out_exp, out_zero, out_ovf
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_mant, out_exp, out_zero, out_ovf
  );

endinterface

// File: rtl/softmax_sum_normalizer_leading_one_norm.sv
// Leading-one detect and left-align: acc -> 1.f * 2^e.
// Latency: combinational.
// Backpressure: none.
// Ports: acc_i (sum), exp_o (leading-one index), mant_o (bits below the leading one), zero_o.
module leading_one_norm
  import softmax_sum_normalizer_pkg::*;
(
  input  logic [ACC_WIDTH-1:0]  acc_i,
  output logic [EXP_WIDTH-1:0]  exp_o,
  output logic [MANT_WIDTH-1:0] mant_o,
  output logic                  zero_o
);

  logic [EXP_WIDTH-1:0] lead;
  logic [EXP_WIDTH:0]   shamt;
  logic [ACC_WIDTH-1:0] aligned;

  always_comb begin
    lead = '0;
    // Ascending scan: the last hit wins, so lead ends on the highest set bit.
    for (int i = 0; i < ACC_WIDTH; i++) begin
      if (acc_i[i]) begin
        lead = EXP_WIDTH'(i);
      end
    end
    // Shifting by ACC_WIDTH-e pushes the hidden one out the top and leaves
    // bits [e-1:0] at the MSB end; low bits are truncated or zero-filled.
    shamt   = (EXP_WIDTH + 1)'(ACC_WIDTH) - {1'b0, lead};
    aligned = acc_i << shamt;
    exp_o   = lead;
    mant_o  = aligned[ACC_WIDTH-1 -: MANT_WIDTH];
    zero_o  = (acc_i == '0);
  end

endmodule

// File: rtl/softmax_sum_normalizer.sv
// Accumulates unsigned exp terms per vector and emits the normalized sum as fraction + exponent.
// Latency: last beat accepted at edge t -> out_valid after edge t+1; min vector period 3 cycles.
// Backpressure: in_ready drops from the last beat until the result handshakes; result held while out_ready=0.
// Ports: clk, rst_n (async active-low), bus (slave modport: in_* term stream, out_* normalized result).
module softmax_sum_normalizer
  import softmax_sum_normalizer_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  softmax_sum_normalizer_if.slave bus
);

  state_t                state_q;
  logic [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  ovf_q, ovf_d;
  logic                  in_ready_q;
  logic                  out_valid_q;
  norm_t                 res_q;
  logic                  res_ovf_q;

  logic                  beat;
  logic                  sat;
  logic                  cnt_full;
  norm_t                 norm;

  // in_ready_q is only high in ACCUM, so it doubles as the state qualifier.
  assign beat = bus.in_valid & in_ready_q;

  always_comb begin
    {sat, acc_d} = sat_add(acc_q, bus.in_data);
    cnt_full     = (cnt_q == CNT_WIDTH'(N_MAX));
    cnt_d        = cnt_full ? cnt_q : cnt_q + 1'b1;
    ovf_d        = ovf_q | sat | cnt_full;
  end

  leading_one_norm u_lon (
    .acc_i  (acc_q),
    .exp_o  (norm.expn),
    .mant_o (norm.mant),
    .zero_o (norm.zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      res_q       <= '0;
      res_ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (beat) begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            if (bus.in_last) begin
              state_q    <= NORM;
              in_ready_q <= 1'b0;
            end
          end
        end
        NORM: begin
          res_q       <= norm;
          res_ovf_q   <= ovf_q;
          out_valid_q <= 1'b1;
          state_q     <= HOLD;
        end
        HOLD: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            res_q       <= '0;
            res_ovf_q   <= 1'b0;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ACCUM;
          end
        end
        default: begin
          state_q     <= ACCUM;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_mant  = res_q.mant;
  assign bus.out_exp   = res_q.expn;
  assign bus.out_zero  = res_q.zero;
  assign bus.out_ovf   = res_ovf_q;

endmodule

// File: tb/tb_softmax_sum_normalizer.sv
// Directed bench for softmax_sum_normalizer: hand-computed vectors, immediate assertions.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_softmax_sum_normalizer;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  softmax_sum_normalizer_if bus ();

  softmax_sum_normalizer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // One accepted beat: valid for exactly one rising edge.
  task automatic beat(input logic [7:0] d, input logic last);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_data  = 8'h00;
  endtask

  // Called at the first falling edge after the last beat; expects out_valid on the second.
  task automatic expect_result(input string tag, input int e, input int m, input int z, input int o);
    int lat;
    lat = 1;
    while (!bus.out_valid && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, " out_valid"}, 32'(bus.out_valid), 1);
    chk({tag, " latency"},   lat, 2);
    chk({tag, " exp"},       32'(bus.out_exp),  e);
    chk({tag, " mant"},      32'(bus.out_mant), m);
    chk({tag, " zero"},      32'(bus.out_zero), z);
    chk({tag, " ovf"},       32'(bus.out_ovf),  o);
  endtask

  // With out_ready=1 the result handshakes on the next edge and input reopens.
  task automatic drain(input string tag);
    @(negedge clk);
    chk({tag, " drained out_valid"}, 32'(bus.out_valid), 0);
    chk({tag, " drained in_ready"},  32'(bus.in_ready),  1);
  endtask

  initial begin
    clk           = 1'b0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;

    repeat (2) @(negedge clk);
    chk("rst in_ready",  32'(bus.in_ready),  1);
    chk("rst out_valid", 32'(bus.out_valid), 0);
    chk("rst mant",      32'(bus.out_mant),  0);
    chk("rst exp",       32'(bus.out_exp),   0);
    chk("rst zero",      32'(bus.out_zero),  0);
    chk("rst ovf",       32'(bus.out_ovf),   0);
    rst_n = 1'b1;
    @(negedge clk);

    // 3+5+8 = 16 = 1.0 * 2^4
    beat(8'd3, 1'b0);
    beat(8'd5, 1'b0);
    beat(8'd8, 1'b1);
    chk("v1 norm in_ready",  32'(bus.in_ready),  0);
    chk("v1 norm out_valid", 32'(bus.out_valid), 0);
    expect_result("v1", 4, 8'h00, 0, 0);
    drain("v1");

    // 200 = 1100_1000: e=7, bits below = 1001000 -> 1001_0000
    beat(8'd100, 1'b0);
    beat(8'd100, 1'b1);
    expect_result("v2", 7, 8'h90, 0, 0);
    drain("v2");

    // Zero sum, single-beat vector
    beat(8'd0, 1'b1);
    expect_result("v3", 0, 8'h00, 1, 0);
    drain("v3");

    // Exactly N_MAX beats: 16*255 = 4080 = 0xFF0, no overflow; e=11, bits 111_1111_0000 -> 0xFE
    for (int i = 0; i < 16; i++) beat(8'hFF, i == 15);
    expect_result("v4", 11, 8'hFE, 0, 0);
    drain("v4");

    // 17 beats: count overflow and saturation at 4095
    for (int i = 0; i < 17; i++) beat(8'hFF, i == 16);
    expect_result("v5", 11, 8'hFF, 0, 1);
    drain("v5");

    // Back-pressure: 6 = 110 -> e=2, mant 0x80; held 5 cycles while in_valid pulses
    bus.out_ready = 1'b0;
    beat(8'd6, 1'b1);
    expect_result("v6", 2, 8'h80, 0, 0);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'hFF;
      bus.in_last  = 1'b1;
      @(negedge clk);
      chk("v6 hold out_valid", 32'(bus.out_valid), 1);
      chk("v6 hold in_ready",  32'(bus.in_ready),  0);
      chk("v6 hold exp",       32'(bus.out_exp),   2);
      chk("v6 hold mant",      32'(bus.out_mant),  8'h80);
    end
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.in_data   = 8'h00;
    bus.out_ready = 1'b1;
    drain("v6");

    // Ignored pulses must not have leaked into this sum
    beat(8'd1, 1'b1);
    expect_result("v7", 0, 8'h00, 0, 0);
    drain("v7");

    // Reset mid-vector discards 50+60
    beat(8'd50, 1'b0);
    beat(8'd60, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst in_ready",  32'(bus.in_ready),  1);
    chk("midrst out_valid", 32'(bus.out_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("postrst out_valid", 32'(bus.out_valid), 0);
    beat(8'd4, 1'b1);
    expect_result("v8", 2, 8'h00, 0, 0);
    drain("v8");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
